video_pos_tracker: RTL and testbench

- Parametrised pixel/line position tracker for the video_mix datapath; successor to the fixed 1920-wide pixel counter.
- Derives the pixel index within the active line and the active-line index within the frame from raw hs/vs/de.
- Does not rely on a hard-coded line length. It measures active width and height on the fly, counts frames, flags frame/line boundaries, and reports lock once the timing is stable.
- Downstream mixers and overlay logic use hcnt/vcnt for addressing and use locked to gate output.

---
 rtl/video_pos_tracker.sv | 153 +++++++++++++++
 tb/tb_video_pos_tracker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/video_pos_tracker.sv
// video_pos_tracker: recovers pixel and line position from raw hs/vs/de video timing.
// It measures the active width and height on the fly and counts frames.
// It asserts locked once the frame geometry has stayed unchanged for STABLE_FRAMES frames.
//
// Ports:
//   clk        pixel clock
//   rst        synchronous, active-high reset
//   hs         horizontal sync; registered for debug only, lines are delimited by de
//   vs         vertical sync, active level set by VS_POL
//   de         data enable
//   pix_valid  registered de; qualifies hcnt/vcnt
//   hcnt       pixel index in the current active line (saturating)
//   vcnt       active-line index in the current frame (saturating)
//   sof        one-cycle pulse on the first pix_valid of a frame
//   eol        one-cycle pulse one cycle after the last pixel of a line
//   hact       pixel count of the last completed line
//   vact       active-line count of the last completed frame
//   fcnt       frame counter, wraps
//   locked     frame timing stable
module video_pos_tracker #(
  parameter int unsigned CW            = 12,
  parameter int unsigned FCW           = 8,
  parameter bit          VS_POL        = 1'b1,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hs,
  input  logic           vs,
  input  logic           de,
  output logic           pix_valid,
  output logic [CW-1:0]  hcnt,
  output logic [CW-1:0]  vcnt,
  output logic           sof,
  output logic           eol,
  output logic [CW-1:0]  hact,
  output logic [CW-1:0]  vact,
  output logic [FCW-1:0] fcnt,
  output logic           locked
);

  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [3:0]    SF   = 4'(STABLE_FRAMES);

  typedef enum logic [1:0] {StUnref, StTrack, StLock} state_t;

  state_t        state;
  logic          de_q, vsa_q, hs_q, sof_pend, line_err;
  logic [CW-1:0] ref_h, ref_v;
  logic [3:0]    stab;

  logic          vsa, vs_rise, de_rise, de_fall;
  logic [CW:0]   hcnt_inc, vcnt_inc;
  logic [CW-1:0] line_w, vcnt_sat, hact_new, vact_new;
  logic [3:0]    stab_inc;
  logic          h_mis, frame_ok;

  always_comb begin
    vsa      = VS_POL ? vs : ~vs;
    vs_rise  = vsa & ~vsa_q;
    de_rise  = de & ~de_q;
    de_fall  = de_q & ~de;
    // Increments are formed one bit wider so the carry marks saturation.
    hcnt_inc = {1'b0, hcnt} + (CW+1)'(1);
    vcnt_inc = {1'b0, vcnt} + (CW+1)'(1);
    line_w   = hcnt_inc[CW] ? CMAX : hcnt_inc[CW-1:0];
    vcnt_sat = vcnt_inc[CW] ? CMAX : vcnt_inc[CW-1:0];
    // Values hact/vact take at this edge, so a line ending together with vs still counts.
    hact_new = de_fall ? line_w : hact;
    vact_new = de_fall ? vcnt_sat : vcnt;
    h_mis    = de_fall & (line_w != ref_h);
    frame_ok = ~(line_err | h_mis) & (vact_new == ref_v) & (vact_new != '0);
    stab_inc = (stab >= SF) ? SF : stab + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q      <= 1'b0;
      vsa_q     <= 1'b0;
      hs_q      <= 1'b0;
      pix_valid <= 1'b0;
      hcnt      <= '0;
      vcnt      <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      hact      <= '0;
      vact      <= '0;
      fcnt      <= '0;
      locked    <= 1'b0;
      sof_pend  <= 1'b0;
      line_err  <= 1'b0;
      ref_h     <= '0;
      ref_v     <= '0;
      stab      <= '0;
      state     <= StUnref;
    end else begin
      de_q      <= de;
      vsa_q     <= vsa;
      hs_q      <= hs;
      pix_valid <= de;
      // The saturated increment of hcnt equals line_w.
      hcnt      <= (de & de_q) ? line_w : '0;
      eol       <= de_fall;
      sof       <= de_rise & sof_pend;
      if (de_fall) hact <= line_w;

      if (vs_rise) begin
        vact     <= vact_new;
        vcnt     <= '0;
        fcnt     <= fcnt + FCW'(1);
        // Setting wins over clearing when vs rises on a first pixel.
        sof_pend <= 1'b1;
        line_err <= 1'b0;
      end else begin
        if (de_fall) vcnt <= vcnt_sat;
        if (de_rise) sof_pend <= 1'b0;
        if (h_mis) line_err <= 1'b1;
      end

      if (vs_rise) begin
        case (state)
          StUnref: begin
            ref_h  <= hact_new;
            ref_v  <= vact_new;
            stab   <= '0;
            state  <= StTrack;
            locked <= 1'b0;
          end
          default: begin
            if (frame_ok) begin
              stab <= stab_inc;
              if (stab_inc == SF) begin
                state  <= StLock;
                locked <= 1'b1;
              end
            end else begin
              ref_h  <= hact_new;
              ref_v  <= vact_new;
              stab   <= '0;
              state  <= StTrack;
              locked <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  // hs is kept only as a registered debug tap.
  logic unused_hs_q;
  assign unused_hs_q = hs_q;

endmodule

// File: tb/tb_video_pos_tracker.sv
module tb_video_pos_tracker;

  logic clk = 1'b0;
  logic rst, hs, vs, de;
  logic vs_n;
  assign vs_n = ~vs;

  always #5 clk = ~clk;

  // a: default parameters, vs active-high.
  logic        a_pix_valid, a_sof, a_eol, a_locked;
  logic [11:0] a_hcnt, a_vcnt, a_hact, a_vact;
  logic [7:0]  a_fcnt;
  // b: narrow counters, vs active-low, driven with the inverted vs.
  logic        b_pix_valid, b_sof, b_eol, b_locked;
  logic [3:0]  b_hcnt, b_vcnt, b_hact, b_vact;
  logic [1:0]  b_fcnt;

  video_pos_tracker dut_a (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .de(de),
    .pix_valid(a_pix_valid), .hcnt(a_hcnt), .vcnt(a_vcnt), .sof(a_sof), .eol(a_eol),
    .hact(a_hact), .vact(a_vact), .fcnt(a_fcnt), .locked(a_locked)
  );

  video_pos_tracker #(.CW(4), .FCW(2), .VS_POL(1'b0), .STABLE_FRAMES(2)) dut_b (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs_n), .de(de),
    .pix_valid(b_pix_valid), .hcnt(b_hcnt), .vcnt(b_vcnt), .sof(b_sof), .eol(b_eol),
    .hact(b_hact), .vact(b_vact), .fcnt(b_fcnt), .locked(b_locked)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  // One active line of n pixels at line index v, then a two-cycle gap.
  // With vs_end, vs rises on the de_fall cycle.
  task automatic send_line(input int n, input int v, input bit sof_exp, input bit vs_end);
    for (int i = 0; i < n; i++) begin
      de = 1'b1;
      hs = 1'b0;
      tick();
      chk("a.pix_valid", a_pix_valid, 1);
      chk("b.pix_valid", b_pix_valid, 1);
      chk("a.hcnt", a_hcnt, i);
      chk("b.hcnt", b_hcnt, sat15(i));
      chk("a.vcnt", a_vcnt, v);
      chk("b.vcnt", b_vcnt, sat15(v));
      chk("a.sof", a_sof, (i == 0) && sof_exp);
      chk("b.sof", b_sof, (i == 0) && sof_exp);
    end
    de = 1'b0;
    if (vs_end) vs = 1'b1;
    tick();
    chk("a.eol", a_eol, 1);
    chk("b.eol", b_eol, 1);
    chk("a.pix_valid_off", a_pix_valid, 0);
    chk("a.hact", a_hact, n);
    chk("b.hact", b_hact, sat15(n));
    chk("a.vcnt_end", a_vcnt, vs_end ? 0 : v + 1);
    chk("b.vcnt_end", b_vcnt, vs_end ? 0 : sat15(v + 1));
    hs = 1'b1;
    tick();
    chk("a.eol_pulse", a_eol, 0);
    chk("b.eol_pulse", b_eol, 0);
    hs = 1'b0;
  endtask

  task automatic send_frame(input int v0, input bit sof_exp);
    for (int l = 0; l < 4; l++) send_line(8, v0 + l, sof_exp && (l == 0), 1'b0);
  endtask

  task automatic vs_pulse(input int vact_e, input int fa, input int fb, input bit lk);
    vs = 1'b1;
    tick();
    chk("a.vact", a_vact, vact_e);
    chk("b.vact", b_vact, sat15(vact_e));
    chk("a.vcnt_vs", a_vcnt, 0);
    chk("b.vcnt_vs", b_vcnt, 0);
    chk("a.fcnt", a_fcnt, fa);
    chk("b.fcnt", b_fcnt, fb);
    chk("a.locked", a_locked, lk);
    chk("b.locked", b_locked, lk);
    tick();
    vs = 1'b0;
    tick();
    chk("a.fcnt_hold", a_fcnt, fa);
  endtask

  task automatic chk_all_zero();
    chk("a.rst_pix_valid", a_pix_valid, 0);
    chk("a.rst_hcnt", a_hcnt, 0);
    chk("a.rst_vcnt", a_vcnt, 0);
    chk("a.rst_sof", a_sof, 0);
    chk("a.rst_eol", a_eol, 0);
    chk("a.rst_hact", a_hact, 0);
    chk("a.rst_vact", a_vact, 0);
    chk("a.rst_fcnt", a_fcnt, 0);
    chk("a.rst_locked", a_locked, 0);
    chk("b.rst_pix_valid", b_pix_valid, 0);
    chk("b.rst_hcnt", b_hcnt, 0);
    chk("b.rst_vcnt", b_vcnt, 0);
    chk("b.rst_hact", b_hact, 0);
    chk("b.rst_vact", b_vact, 0);
    chk("b.rst_fcnt", b_fcnt, 0);
    chk("b.rst_locked", b_locked, 0);
  endtask

  initial begin
    rst = 1'b1;
    hs  = 1'b0;
    vs  = 1'b0;
    de  = 1'b0;
    tick();
    tick();
    chk_all_zero();
    rst = 1'b0;
    tick();

    // Three clean 8x4 frames, vs after each; lock on the third vs.
    send_frame(0, 1'b0);
    vs_pulse(4, 1, 1, 1'b0);
    send_frame(0, 1'b1);
    vs_pulse(4, 2, 2, 1'b0);
    send_frame(0, 1'b1);
    vs_pulse(4, 3, 3, 1'b1);

    // Frame with one 7-pixel line: lock holds until the vs, then drops.
    send_line(8, 0, 1'b1, 1'b0);
    send_line(7, 1, 1'b0, 1'b0);
    chk("a.locked_midframe", a_locked, 1);
    send_line(8, 2, 1'b0, 1'b0);
    send_line(8, 3, 1'b0, 1'b0);
    vs_pulse(4, 4, 0, 1'b0);
    send_frame(0, 1'b1);
    vs_pulse(4, 5, 1, 1'b0);
    send_frame(0, 1'b1);
    vs_pulse(4, 6, 2, 1'b1);

    // vs rises on the de_fall of the last line.
    send_line(8, 0, 1'b1, 1'b0);
    send_line(8, 1, 1'b0, 1'b0);
    send_line(8, 2, 1'b0, 1'b0);
    send_line(8, 3, 1'b0, 1'b1);
    chk("a.vact_coinc", a_vact, 4);
    chk("b.vact_coinc", b_vact, 4);
    chk("a.fcnt_coinc", a_fcnt, 7);
    chk("b.fcnt_coinc", b_fcnt, 3);
    chk("a.locked_coinc", a_locked, 1);
    vs = 1'b0;
    tick();

    // Two frames with vs idle: no frame events, lines keep counting.
    send_frame(0, 1'b1);
    send_frame(4, 1'b0);
    chk("a.fcnt_novs", a_fcnt, 7);
    chk("b.fcnt_novs", b_fcnt, 3);
    chk("a.vcnt_novs", a_vcnt, 8);
    vs_pulse(8, 8, 0, 1'b0);

    // 20-pixel line: narrow instance saturates at 15.
    send_line(20, 0, 1'b1, 1'b0);

    // Reset in the middle of a line.
    for (int i = 0; i < 3; i++) begin
      de = 1'b1;
      tick();
    end
    chk("a.hcnt_prerst", a_hcnt, 2);
    rst = 1'b1;
    tick();
    chk_all_zero();
    de = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Lock must be rebuilt from scratch.
    send_frame(0, 1'b0);
    vs_pulse(4, 1, 1, 1'b0);
    send_frame(0, 1'b1);
    vs_pulse(4, 2, 2, 1'b0);
    send_frame(0, 1'b1);
    vs_pulse(4, 3, 3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
